// File: rtl/seq_frame_tx_pkg.sv
// Shared types and constants for the serial frame transmitter and its detector.
package seq_frame_tx_pkg;

  typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;

  localparam int PAT_W = 12;
  localparam logic [PAT_W-1:0] SYNC_WORD = 12'b111000000111;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bit counter width; never narrower than one bit.
  function automatic int cnt_width(input int pat_w, input int data_w);
    int m;
    m = max_int(pat_w, data_w);
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/seq_frame_tx_shreg.sv
// Parallel-load, MSB-first payload shift register for the frame transmitter.
module frame_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= sr << 1;
    end
  end

  assign msb = sr[W-1];

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync word then payload, MSB-first, gapless back-to-back.
//
//   state | meaning
//   IDLE  | line at IDLE_BIT, ready for a start request
//   SYNC  | shifting out sync word bit bit_cnt
//   DATA  | shifting out payload bit bit_cnt; ready again at bit_cnt=0
module seq_frame_tx #(
  parameter int             PAT_W    = seq_frame_tx_pkg::PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = seq_frame_tx_pkg::SYNC_WORD,
  parameter int             DATA_W   = 8,
  parameter logic           IDLE_BIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              x_o,
  output logic              valid_o,
  output logic              done_o
);
  import seq_frame_tx_pkg::*;

  localparam int CNT_W = cnt_width(PAT_W, DATA_W);

  state_t           state, state_nx;
  logic [CNT_W-1:0] bit_cnt, cnt_nx;
  logic             accept;
  logic             data_msb;
  logic             x_nx, valid_nx, done_nx;

  assign ready_o = (state == IDLE) || ((state == DATA) && (bit_cnt == '0));
  assign accept  = ready_o && start_i;

  always_comb begin
    state_nx = state;
    cnt_nx   = bit_cnt;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_nx = SYNC;
          cnt_nx   = CNT_W'(PAT_W - 1);
        end
      end
      SYNC: begin
        if (bit_cnt == '0) begin
          state_nx = DATA;
          cnt_nx   = CNT_W'(DATA_W - 1);
        end else begin
          cnt_nx = bit_cnt - CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_cnt == '0) begin
          if (start_i) begin
            state_nx = SYNC;
            cnt_nx   = CNT_W'(PAT_W - 1);
          end else begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end
        end else begin
          cnt_nx = bit_cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state view, so x_o lines up with state/bit_cnt.
  always_comb begin
    x_nx     = IDLE_BIT;
    valid_nx = (state_nx != IDLE);
    done_nx  = (state_nx == DATA) && (cnt_nx == '0);
    case (state_nx)
      SYNC:    x_nx = PATTERN[cnt_nx];
      DATA:    x_nx = data_msb;
      default: x_nx = IDLE_BIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      x_o     <= IDLE_BIT;
      valid_o <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state   <= state_nx;
      bit_cnt <= cnt_nx;
      x_o     <= x_nx;
      valid_o <= valid_nx;
      done_o  <= done_nx;
    end
  end

  // The shift register advances each time a payload bit is moved into x_o.
  frame_shreg #(
    .W (DATA_W)
  ) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (state_nx == DATA),
    .din   (data_i),
    .msb   (data_msb)
  );

endmodule

// File: tb/tb_seq_frame_tx.sv
// Scoreboard bench for seq_frame_tx with a behavioural loopback sync detector.
module tb_seq_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic [7:0] data_i;
  logic       ready_o, x_o, valid_o, done_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [1:0] exp_q[$];
  logic [7:0] send_q[$];
  int nvalid, ndone, ndet, det_idx, first_v, last_v;
  bit perturb = 1'b0;

  logic [11:0] det_win;
  logic        det;

  always #5 clk = ~clk;

  seq_frame_tx dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .x_o     (x_o),
    .valid_o (valid_o),
    .done_o  (done_o)
  );

  // Detector model fed by x_o: fires the cycle after the sync word's last bit.
  always @(posedge clk) begin
    if (rst) begin
      det_win <= '0;
      det     <= 1'b0;
    end else begin
      det_win <= {det_win[10:0], x_o};
      det     <= ({det_win[10:0], x_o} == 12'b111000000111);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic push_frame(input logic [7:0] d);
    logic [19:0] bits;
    bits = {12'b111000000111, d};
    for (int i = 19; i >= 0; i--) exp_q.push_back({bits[i], 1'(i == 0)});
  endtask

  task automatic run_traffic(input int max_cycles);
    logic [1:0] e;
    nvalid = 0; ndone = 0; ndet = 0; det_idx = -1; first_v = -1; last_v = -1;
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      if (valid_o) begin
        nvalid++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        if (done_o) ndone++;
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL extra_bit: cycle %0d got valid_o=1, required no frame bit", cyc);
        end else begin
          e = exp_q.pop_front();
          if ({x_o, done_o, ready_o} !== {e[1], e[0], e[0]})
            $display("FAIL frame_bit: cycle %0d got x/done/ready=%b%b%b, required %b%b%b",
                     cyc, x_o, done_o, ready_o, e[1], e[0], e[0]);
          else pass_cnt++;
        end
      end else begin
        total_cnt++;
        if ({x_o, done_o, ready_o} !== 3'b001)
          $display("FAIL idle_out: cycle %0d got x/done/ready=%b%b%b, required 001",
                   cyc, x_o, done_o, ready_o);
        else pass_cnt++;
      end
      if (det) begin
        ndet++;
        det_idx = nvalid;
      end
      if (send_q.size() == 0 && exp_q.size() == 0 && !valid_o && cyc > 0) break;
      if (ready_o && send_q.size() > 0) begin
        start_i = 1'b1;
        data_i  = send_q.pop_front();
        push_frame(data_i);
      end else if (!ready_o && perturb) begin
        start_i = 1'($urandom);
        data_i  = 8'($urandom);
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
    end
    start_i = 1'b0;
    total_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL drain: %0d expected bits left unsent, required 0", exp_q.size());
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b1; data_i = 8'h5A;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total_cnt++;
      if ({x_o, valid_o, ready_o, done_o} !== 4'b0010)
        $display("FAIL reset_hold: got x/valid/ready/done=%b%b%b%b, required 0010",
                 x_o, valid_o, ready_o, done_o);
      else pass_cnt++;
    end
    rst = 1'b0; start_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total_cnt++;
      if ({x_o, valid_o, ready_o, done_o} !== 4'b0010)
        $display("FAIL reset_idle: cycle %0d got x/valid/ready/done=%b%b%b%b, required 0010",
                 k, x_o, valid_o, ready_o, done_o);
      else pass_cnt++;
    end
  endtask

  task automatic test_loopback();
    send_q.push_back(8'h00);
    run_traffic(60);
    total_cnt++;
    if (nvalid !== 20) $display("FAIL loop_len: got %0d valid cycles, required 20", nvalid);
    else pass_cnt++;
    total_cnt++;
    if (ndet !== 1) $display("FAIL loop_det_count: got %0d det pulses, required 1", ndet);
    else pass_cnt++;
    total_cnt++;
    if (det_idx !== 13) $display("FAIL loop_det_pos: got det at valid cycle %0d, required 13", det_idx);
    else pass_cnt++;
  endtask

  task automatic test_single();
    send_q.push_back(8'hA5);
    run_traffic(60);
    total_cnt++;
    if (first_v !== 1) $display("FAIL single_latency: got first valid at cycle %0d, required 1", first_v);
    else pass_cnt++;
    total_cnt++;
    if (nvalid !== 20 || last_v - first_v + 1 !== 20)
      $display("FAIL single_len: got %0d valid over span %0d, required 20/20", nvalid, last_v - first_v + 1);
    else pass_cnt++;
    total_cnt++;
    if (ndone !== 1) $display("FAIL single_done: got %0d done pulses, required 1", ndone);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    send_q.push_back(8'hFF);
    send_q.push_back(8'h0F);
    run_traffic(100);
    total_cnt++;
    if (nvalid !== 40 || last_v - first_v + 1 !== 40)
      $display("FAIL b2b_len: got %0d valid over span %0d, required 40/40", nvalid, last_v - first_v + 1);
    else pass_cnt++;
    total_cnt++;
    if (ndone !== 2) $display("FAIL b2b_done: got %0d done pulses, required 2", ndone);
    else pass_cnt++;
  endtask

  task automatic test_ignore();
    perturb = 1'b1;
    send_q.push_back(8'h96);
    run_traffic(60);
    perturb = 1'b0;
    total_cnt++;
    if (nvalid !== 20 || ndone !== 1)
      $display("FAIL ignore: got %0d valid / %0d done, required 20 / 1", nvalid, ndone);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    logic [1:0] e;
    start_i = 1'b1; data_i = 8'hC3;
    push_frame(8'hC3);
    @(negedge clk);
    start_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      e = exp_q.pop_front();
      total_cnt++;
      if ({valid_o, x_o, done_o} !== {1'b1, e[1], 1'b0})
        $display("FAIL midrst_bit: valid cycle %0d got valid/x/done=%b%b%b, required 1%b0",
                 k, valid_o, x_o, done_o, e[1]);
      else pass_cnt++;
      if (k == 8) rst = 1'b1;
      @(negedge clk);
    end
    exp_q.delete();
    total_cnt++;
    if ({x_o, valid_o, ready_o, done_o} !== 4'b0010)
      $display("FAIL midrst_abort: got x/valid/ready/done=%b%b%b%b, required 0010",
               x_o, valid_o, ready_o, done_o);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({valid_o, done_o} !== 2'b00)
      $display("FAIL midrst_after: got valid/done=%b%b, required 00", valid_o, done_o);
    else pass_cnt++;
    send_q.push_back(8'h3C);
    run_traffic(60);
    total_cnt++;
    if (nvalid !== 20 || ndone !== 1)
      $display("FAIL midrst_refr: got %0d valid / %0d done, required 20 / 1", nvalid, ndone);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; data_i = '0;
    test_reset();
    test_loopback();
    test_single();
    test_back_to_back();
    test_ignore();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/seq_frame_tx.md
# seq_frame_tx

Serial frame transmitter: the transmit-side counterpart of the `detect` block. On a start handshake it shifts out the 12-bit sync word 111000000111 MSB-first, followed by a DATA_W-bit payload word MSB-first, on a single serial line. It sits upstream of the detector and drives its `x_i` input in loopback and system builds. It supports gapless back-to-back frames.

## Interface
- PAT_W, 12: sync word width.
- PATTERN, 12'b111000000111: sync word, sent bit PAT_W-1 first.
- DATA_W, 8: payload width, ≥1.
- IDLE_BIT, 1'b0: line level when no frame is in flight.
- clk  in  1  single clock; everything is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  frame request; accepted only when ready_o=1.
- data_i  in  DATA_W  payload; sampled on the accepting edge only.
- ready_o  out  1  block can accept start_i this cycle.
- x_o  out  1  registered serial bit.
- valid_o  out  1  x_o carries a frame bit this cycle.
- done_o  out  1  one-cycle pulse coincident with the last payload bit.

## Operation
- States: IDLE, SYNC, DATA. A bit counter counts bits within the current state.
- IDLE:
  - x_o=IDLE_BIT, valid_o=0, ready_o=1.
  - start_i=1 latches data_i into the payload register, loads bit_cnt=PAT_W-1 and goes to SYNC.
- SYNC:
  - x_o=PATTERN[bit_cnt], valid_o=1.
  - bit_cnt decrements each cycle.
  - At bit_cnt=0 the next state is DATA with bit_cnt=DATA_W-1.
- DATA:
  - x_o=payload[bit_cnt], valid_o=1.
  - At bit_cnt=0: done_o=1 and ready_o=1.
  - At bit_cnt=0 with start_i=1: data_i is latched and the block goes directly to SYNC with bit_cnt=PAT_W-1. No idle gap.
  - At bit_cnt=0 with start_i=0: the block goes to IDLE.
- ready_o is 0 in SYNC and in DATA except at bit_cnt=0. start_i is ignored while ready_o=0, and data_i changes are ignored until the next acceptance.
- The payload is not scrambled or escaped. A payload or a frame boundary can itself form 111000000111 at a detector, and this block does not prevent it.
- Counter width is $clog2(max(PAT_W,DATA_W)). The counter never wraps below 0, because a state change reloads it.

## Timing
- Reset (rst=1 at an edge) gives state=IDLE, bit_cnt=0, payload=0, x_o=IDLE_BIT, valid_o=0, done_o=0, ready_o=1.
- Reset mid-frame aborts immediately. The next cycle shows the idle values, with no partial-frame completion and no done_o pulse.
- rst has priority over start_i on the same edge.
- Latency: start accepted at edge E. The first sync bit (PATTERN[PAT_W-1]) is on x_o with valid_o=1 in the cycle after E.
- A frame occupies exactly PAT_W+DATA_W consecutive valid cycles: 20 at defaults.
- done_o is high for exactly one cycle per frame: the final valid cycle. ready_o is also high in that cycle.
- Back-to-back: with start_i held high, valid_o stays 1 continuously and frames repeat every PAT_W+DATA_W cycles.
- When looped back into the detector, det_o is high in the cycle after the last sync bit is on x_o. That is the cycle carrying payload bit DATA_W-1.
- All outputs are registered except ready_o. ready_o is decoded from state and bit_cnt, with no combinational path from start_i.

## Structure
- Shared package, also used by the detector bench:
  - state enum {IDLE, SYNC, DATA};
  - default sync-word constant SYNC_WORD = 12'b111000000111;
  - PAT_W constant.
- One sub-module is natural: `frame_shreg`, a parallel-load, MSB-first shift register for the payload. Selection of the sync bit by counter stays in the top level.
- No other hierarchy.

## Test plan
- Reset, then idle 5 cycles -> x_o=0, valid_o=0, ready_o=1, done_o=0 throughout.
- start_i=1 for one cycle with data_i=8'hA5 -> next 20 cycles x_o=1,1,1,0,0,0,0,0,0,1,1,1,1,0,1,0,0,1,0,1. valid_o=1 for all 20. done_o only on the 20th. Then idle.
- Loopback x_o into the detector, data_i=8'h00 -> det_o=1 exactly once, in the cycle after the 12th frame bit.
- start_i held high with data_i=8'hFF then 8'h0F, presented at each ready cycle -> 40 contiguous valid cycles. Two done_o pulses at valid cycles 20 and 40. The second payload is 00001111.
- start_i pulsed and data_i toggled during SYNC -> ignored. The frame content is unchanged and no extra frame is sent.
- rst asserted on the 8th valid cycle of a frame -> the next cycle shows x_o=0, valid_o=0, ready_o=1, with no done_o. A new start then produces a complete, correct frame.
